// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter in front of a shared negative-edge register bank (Q/Qbar).
// The owner may lock the bank for up to MAX_HOLD back-to-back writes.
module dff_bank_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic [NREQ-1:0]          Req,
    input  logic [NREQ-1:0]          Lock,
    input  logic [NREQ*WIDTH-1:0]    Data,
    output logic [NREQ-1:0]          Grant,
    output logic                     Ack,
    output logic [$clog2(NREQ)-1:0]  Owner,
    output logic                     Busy,
    output logic [WIDTH-1:0]         Q,
    output logic [WIDTH-1:0]         Qbar
);

    localparam int unsigned IW = $clog2(NREQ);

    typedef enum logic [1:0] {StIdle, StGrant, StHold} state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [3:0]        hold_q, hold_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              ack_q, ack_d;

    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic [IW-1:0]     cand;
    logic              owner_req;
    logic              owner_lock;
    logic [WIDTH-1:0]  owner_data;
    logic [IW-1:0]     owner_succ;
    logic [3:0]        hold_inc;

    // First requester at or above the pointer, wrapping modulo NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        cand       = ptr_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IW'((32'(ptr_q) + i) % NREQ);
            if (!pick_found && Req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        owner_req  = Req[owner_q];
        owner_lock = Lock[owner_q];
        owner_data = Data[int'(owner_q)*WIDTH +: WIDTH];
        owner_succ = (32'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;
        hold_inc   = hold_q + 4'd1;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        q_d     = q_q;
        ack_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                    owner_d = pick_idx;
                    state_d = StGrant;
                end else begin
                    grant_d = '0;
                end
            end
            StGrant: begin
                if (owner_req) begin
                    q_d    = owner_data;
                    ack_d  = 1'b1;
                    ptr_d  = owner_succ;
                    hold_d = 4'd1;
                    if (owner_lock && (MAX_HOLD > 1)) begin
                        state_d = StHold;
                    end else begin
                        grant_d = '0;
                        state_d = StIdle;
                    end
                end else begin
                    // Requester withdrew before its write: abort, pointer untouched.
                    grant_d = '0;
                    state_d = StIdle;
                end
            end
            StHold: begin
                if (owner_req) begin
                    q_d   = owner_data;
                    ack_d = 1'b1;
                    ptr_d = owner_succ;
                    if (owner_lock) begin
                        hold_d = hold_inc;
                        if (hold_inc == 4'(MAX_HOLD)) begin
                            grant_d = '0;
                            state_d = StIdle;
                        end
                    end else begin
                        grant_d = '0;
                        state_d = StIdle;
                    end
                end else begin
                    grant_d = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(negedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= StIdle;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            q_q     <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            q_q     <= q_d;
            ack_q   <= ack_d;
        end
    end

    assign Grant = grant_q;
    assign Ack   = ack_q;
    assign Owner = owner_q;
    assign Busy  = (state_q != StIdle);
    assign Q     = q_q;
    assign Qbar  = ~q_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter (WIDTH=8, NREQ=4, MAX_HOLD=4).
// Inputs change just after each falling edge; outputs are checked 1 unit after it.
module tb_dff_bank_arbiter;

    logic        Clock;
    logic        Resetn;
    logic [3:0]  Req;
    logic [3:0]  Lock;
    logic [31:0] Data;
    logic [3:0]  Grant;
    logic        Ack;
    logic [1:0]  Owner;
    logic        Busy;
    logic [7:0]  Q;
    logic [7:0]  Qbar;

    int n_cmp = 0;
    int n_err = 0;

    dff_bank_arbiter #(
        .WIDTH    (8),
        .NREQ     (4),
        .MAX_HOLD (4)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Req    (Req),
        .Lock   (Lock),
        .Data   (Data),
        .Grant  (Grant),
        .Ack    (Ack),
        .Owner  (Owner),
        .Busy   (Busy),
        .Q      (Q),
        .Qbar   (Qbar)
    );

    initial Clock = 1'b1;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clock);
        #1;
    endtask

    task automatic pulse_reset();
        Resetn = 1'b0;
        #1;
        Resetn = 1'b1;
    endtask

    logic [1:0] rr_own [5];

    initial begin
        rr_own = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        Resetn = 1'b0;
        Req    = '0;
        Lock   = '0;
        Data   = '0;
        tick();
        check("rst_q", Q, 8'h00);
        check("rst_qbar", Qbar, 8'hFF);
        check("rst_grant", Grant, 4'b0000);
        check("rst_ack", Ack, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_owner", Owner, 2'd0);
        Resetn = 1'b1;

        // Single requester, unlocked
        Req = 4'b0001;
        Data[7:0] = 8'hA5;
        tick();
        check("single_grant", Grant, 4'b0001);
        check("single_busy", Busy, 1'b1);
        check("single_ack0", Ack, 1'b0);
        tick();
        check("single_q", Q, 8'hA5);
        check("single_qbar", Qbar, 8'h5A);
        check("single_ack", Ack, 1'b1);
        check("single_grant_clr", Grant, 4'b0000);
        Req = 4'b0000;
        tick();
        check("single_ack_end", Ack, 1'b0);
        check("single_grant_end", Grant, 4'b0000);
        check("single_idle", Busy, 1'b0);

        // Round robin with all requesting
        pulse_reset();
        Data = {8'h13, 8'h12, 8'h11, 8'h10};
        Req  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_grant", Grant, 4'b0001 << rr_own[k]);
            check("rr_owner", Owner, rr_own[k]);
            check("rr_ack_gap", Ack, 1'b0);
            tick();
            check("rr_q", Q, 8'h10 + rr_own[k]);
            check("rr_ack", Ack, 1'b1);
        end
        Req = 4'b0000;
        tick();
        check("rr_idle", Busy, 1'b0);

        // Wrap and skip: owner 2 sets pointer to 3
        Req = 4'b0100;
        tick();
        check("wrap_g2", Grant, 4'b0100);
        tick();
        check("wrap_q2", Q, 8'h12);
        Req = 4'b0101;
        tick();
        check("wrap_g0", Grant, 4'b0001);
        check("wrap_o0", Owner, 2'd0);
        tick();
        check("wrap_q0", Q, 8'h10);
        tick();
        check("wrap_g2b", Grant, 4'b0100);
        check("wrap_o2b", Owner, 2'd2);
        tick();
        check("wrap_q2b", Q, 8'h12);
        Req = 4'b0000;
        tick();

        // Lock limit: exactly four writes, then release
        Req = 4'b0010;
        Lock = 4'b0010;
        Data[15:8] = 8'd1;
        tick();
        check("lock_grant", Grant, 4'b0010);
        for (int v = 1; v <= 4; v++) begin
            tick();
            check("lock_q", Q, v);
            check("lock_ack", Ack, 1'b1);
            check("lock_grant_hold", Grant, (v == 4) ? 4'b0000 : 4'b0010);
            Data[15:8] = 8'(v + 1);
        end
        tick();
        check("lock_regrant", Grant, 4'b0010);
        check("lock_regrant_ack", Ack, 1'b0);
        check("lock_q_steady", Q, 8'd4);
        tick();
        check("lock_q5", Q, 8'd5);
        check("lock_hold5", Grant, 4'b0010);
        // Non-owner request ignored while held; dropping Lock gives a final write
        Req = 4'b0110;
        Lock = 4'b0000;
        Data[15:8] = 8'd6;
        Data[23:16] = 8'h22;
        tick();
        check("unlock_q", Q, 8'd6);
        check("unlock_ack", Ack, 1'b1);
        check("unlock_grant", Grant, 4'b0000);
        tick();
        check("next_owner2", Grant, 4'b0100);
        Req = 4'b0000;
        tick();
        check("abort2_grant", Grant, 4'b0000);
        check("abort2_ack", Ack, 1'b0);
        check("abort2_q", Q, 8'd6);
        check("abort2_busy", Busy, 1'b0);
        Req = 4'b0101;
        tick();
        check("abort2_ptr", Grant, 4'b0100);
        Req = 4'b0000;
        tick();

        // Abort with pointer at 0
        pulse_reset();
        Req = 4'b1000;
        tick();
        check("abort_grant", Grant, 4'b1000);
        Req = 4'b0000;
        tick();
        check("abort_grant_clr", Grant, 4'b0000);
        check("abort_ack", Ack, 1'b0);
        check("abort_q", Q, 8'h00);
        Req = 4'b1001;
        tick();
        check("abort_ptr", Grant, 4'b0001);
        check("abort_owner", Owner, 2'd0);
        tick();
        check("abort_after_q", Q, 8'h10);
        Req = 4'b0000;
        tick();

        // Asynchronous reset in the middle of a hold
        Req = 4'b0010;
        Lock = 4'b0010;
        Data[15:8] = 8'h77;
        tick();
        tick();
        check("hold_q", Q, 8'h77);
        check("hold_busy", Busy, 1'b1);
        #2;
        Resetn = 1'b0;
        #1;
        check("arst_q", Q, 8'h00);
        check("arst_qbar", Qbar, 8'hFF);
        check("arst_grant", Grant, 4'b0000);
        check("arst_ack", Ack, 1'b0);
        check("arst_busy", Busy, 1'b0);
        Req = 4'b0000;
        Lock = 4'b0000;
        Resetn = 1'b1;
        tick();
        check("arst_after_busy", Busy, 1'b0);
        check("arst_after_q", Q, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
